// File: rtl/mac_operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mac_seq_pkg
//   Shared types and default sizes for the MAC operand sequencer.
//   - state_t      : sequencer FSM states
//   - MAC_DATA_W   : default operand width (matches the 11x11 MAC inputs)
//   - MAC_DEPTH    : default entries per operand bank (maximum vector length)
//   - MAC_RESULT_W : width of the MAC accumulator / captured result
// ---------------------------------------------------------------------------
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int MAC_DATA_W   = 11;
    localparam int MAC_DEPTH    = 8;
    localparam int MAC_RESULT_W = 2 * MAC_DATA_W;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// mac_operand_sequencer_if
//   Bundles the host write port, run control and the MAC-facing operand
//   outputs of the sequencer.
//   - master : host / MAC side (drives wr_*, len, start, mac_sum)
//   - slave  : sequencer side (drives busy, k_out, l_out, acc_clr,
//              pair_valid, done, result, result_valid)
//   With MAC_OPERAND_SEQUENCER_RESULT_CAPTURE_EN defined the interface also
//   carries mac_sum, result and result_valid.
// ---------------------------------------------------------------------------
interface mac_operand_sequencer_if
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int ADDR_W = $clog2(MAC_DEPTH)
);
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   len;
    logic              start;
    logic              busy;
    logic [DATA_W-1:0] k_out;
    logic [DATA_W-1:0] l_out;
    logic              acc_clr;
    logic              pair_valid;
    logic              done;
`ifdef MAC_OPERAND_SEQUENCER_RESULT_CAPTURE_EN
    logic [2*DATA_W-1:0] mac_sum;
    logic [2*DATA_W-1:0] result;
    logic                result_valid;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, len, start, mac_sum,
        input  busy, k_out, l_out, acc_clr, pair_valid, done, result, result_valid
    );
    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, len, start, mac_sum,
        output busy, k_out, l_out, acc_clr, pair_valid, done, result, result_valid
    );
`else
    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, len, start,
        input  busy, k_out, l_out, acc_clr, pair_valid, done
    );
    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, len, start,
        output busy, k_out, l_out, acc_clr, pair_valid, done
    );
`endif

endinterface

// File: rtl/mac_operand_sequencer_bank.sv
// ---------------------------------------------------------------------------
// mac_operand_bank
//   DEPTH x DATA_W operand register file, one write port, one registered
//   read port, asynchronous clear of every entry.
//   Ports:
//     clock, reset       : system clock, async active-high clear
//     wr_en/addr/data    : write port (takes effect on the clock edge)
//     rd_en, rd_addr     : read request; rd_data is 0 when rd_en is low
//     rd_data            : registered read data (drives the MAC operand)
// ---------------------------------------------------------------------------
module mac_operand_bank
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int DEPTH  = MAC_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // NOTE: every signal assigned in always_comb gets its default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        // Gating the read to 0 makes the read register double as the
        // zero-when-idle operand register.
        rd_data_d = rd_en ? mem_q[rd_addr] : '0;
    end

    // NOTE: the banks must read 0 after reset, so every entry is on the async
    // clear; this array therefore maps to flops, not to a reset-less RAM.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mac_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mac_operand_sequencer
//   Upstream feeder for an 11x11 multiply-accumulate stage. On start it
//   clears the MAC for one cycle, streams len operand pairs (one per clock)
//   from the K and L banks, then pulses done. Operands are 0 whenever no
//   pair is being streamed so the free-running MAC holds its sum.
//   Ports:
//     clock, reset : system clock, async active-high reset
//     bus (slave)  : host write port, len/start, busy, k_out/l_out,
//                    acc_clr, pair_valid, done
//   Optional: MAC_OPERAND_SEQUENCER_RESULT_CAPTURE_EN adds mac_sum input and
//   result/result_valid outputs that capture the final MAC sum after done.
// ---------------------------------------------------------------------------
module mac_operand_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int DEPTH  = MAC_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    mac_operand_sequencer_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              acc_clr_q, acc_clr_d;
    logic              pair_valid_q, pair_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // Outputs trail the state by one register stage. A new run (or a bank
    // write) is accepted only once the DONE outputs have retired, so the
    // visible busy covers every cycle in which requests are ignored.
    logic accept;
    logic stream_last;
    logic rd_en;
    assign accept      = (state_q == IDLE) && !busy_q;
    assign stream_last = (({1'b0, idx_q} + (ADDR_W + 1)'(1)) == len_q);
    assign rd_en       = (state_q == STREAM);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && accept) begin
                    len_d   = (bus.len > DEPTH_LEN) ? DEPTH_LEN : bus.len;
                    idx_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR:   state_d = (len_q != '0) ? STREAM : DONE;
            STREAM: begin
                if (stream_last) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        acc_clr_d    = (state_q == CLEAR);
        pair_valid_d = (state_q == STREAM);
        done_d       = (state_q == DONE);
        busy_d       = (state_q != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            acc_clr_q    <= 1'b0;
            pair_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            acc_clr_q    <= acc_clr_d;
            pair_valid_q <= pair_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.acc_clr    = acc_clr_q;
    assign bus.pair_valid = pair_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;

    // The bank read registers are the k_out/l_out output registers; reads are
    // issued from the STREAM state so data lands in the same cycle as
    // pair_valid.
    mac_operand_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_k_bank (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (bus.wr_en && accept && !bus.wr_sel),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (idx_q),
        .rd_data (bus.k_out)
    );

    mac_operand_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_l_bank (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (bus.wr_en && accept && bus.wr_sel),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (idx_q),
        .rd_data (bus.l_out)
    );

`ifdef MAC_OPERAND_SEQUENCER_RESULT_CAPTURE_EN
    localparam int RES_W = 2 * DATA_W;

    logic [RES_W-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;

    // done is high in the cycle the MAC sum becomes final, so the capture
    // happens on the edge that ends that cycle.
    always_comb begin
        result_d       = done_q ? bus.mac_sum : result_q;
        result_valid_d = done_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
`endif

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Upstream feeder for the 11x11 multiply-accumulate stage, which sums k*l every clock into a 22-bit accumulator and clears on its synchronous reset input.
- Holds two small operand banks (K and L), each written by a host port.
- On start: clears the MAC for one cycle, then streams len operand pairs (k_out, l_out) one per clock, then pulses done.
- Drives zero operands whenever not streaming, so the free-running MAC holds its sum.

Parameters:
- DATA_W, 11, operand width (matches the MAC k/l inputs)
- DEPTH, 8, entries per bank (maximum vector length)
- ADDR_W, 3, bank address width, equal to clog2(DEPTH)

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  bank write strobe
- wr_sel  input  1  bank select: 0 = K bank, 1 = L bank
- wr_addr  input  ADDR_W  bank write address
- wr_data  input  DATA_W  bank write data
- len  input  ADDR_W+1  vector length, sampled on accepted start
- start  input  1  begin a dot-product run
- busy  output  1  high in CLEAR, STREAM and DONE
- k_out  output  DATA_W  operand to the MAC k input
- l_out  output  DATA_W  operand to the MAC l input
- acc_clr  output  1  drives the MAC reset input
- pair_valid  output  1  high while k_out/l_out carry a real pair
- done  output  1  one-cycle pulse at the end of a run

Behaviour:
- Reset: one clock, asynchronous and active-high.
  - Forces state IDLE and index 0.
  - Outputs: k_out=0, l_out=0, acc_clr=0, pair_valid=0, done=0, busy=0.
  - Clears both banks to 0.
  - Reset mid-run aborts immediately; no done pulse.
- All outputs are registered.
- States: IDLE -> CLEAR -> STREAM -> DONE -> IDLE.
- IDLE:
  - Writes accepted: bank[wr_sel][wr_addr] <= wr_data on the clock edge.
  - start=1 latches len_q and moves to CLEAR.
  - len_q = min(len, DEPTH).
- Simultaneous wr_en and start in IDLE: both take effect, and the written value is visible to the run.
- CLEAR: exactly 1 cycle.
  - acc_clr=1, k_out=l_out=0.
  - Next state is STREAM if len_q>0, else DONE.
- STREAM: lasts len_q cycles, i = 0 .. len_q-1.
  - k_out=K[i], l_out=L[i], pair_valid=1, acc_clr=0.
  - Moves to DONE after i = len_q-1.
  - No wrap: the index never exceeds len_q-1.
- DONE: exactly 1 cycle.
  - done=1, k_out=l_out=0, pair_valid=0.
  - Next state is IDLE.
- Latency: first pair appears 2 cycles after the start edge. done appears len_q+2 cycles after the start edge.
- Conditions ignored while busy:
  - start (no queueing)
  - wr_en (banks are frozen during a run)
- len=0 runs CLEAR then DONE; the MAC result is 0.
- Outside STREAM, k_out and l_out are always 0, so the MAC adds 0.
- Consequence: the MAC sum is final in the cycle done is high, and stays stable afterwards.

Optional Feature:
- Macro: MAC_OPERAND_SEQUENCER_RESULT_CAPTURE_EN.
- When defined, add these ports:
  - input mac_sum [2*DATA_W-1:0]
  - output result [2*DATA_W-1:0]
  - output result_valid 1
- result <= mac_sum on the edge ending the DONE cycle.
- result_valid pulses 1 cycle, in the cycle after done.
- result holds until the next capture; reset clears result and result_valid to 0.
- When undefined: the ports and registers are absent, and behaviour is otherwise identical.

Decomposition:
- Package mac_seq_pkg holds:
  - state enum {IDLE, CLEAR, STREAM, DONE}
  - default DATA_W and DEPTH constants
  - RESULT_W = 2*DATA_W
- One natural sub-module, mac_operand_bank: a DEPTH x DATA_W register file with one write port, one registered read port and async clear. It is instantiated twice (K and L).
- FSM and index counter stay in the top module.

Test Plan:
- Load K={3,2,8}, L={5,9,3}, len=3, start.
  - acc_clr is high 1 cycle, then pairs (3,5),(2,9),(8,3) each with pair_valid, then done.
  - With the MAC attached, the sum is 57 in the done cycle; with the macro, result=57.
- len=0, start: CLEAR then DONE. done is 2 cycles after start, pair_valid never asserts, MAC sum 0.
- DEPTH=8, len=12, start: exactly 8 STREAM cycles. done is 10 cycles after start.
- Start run with len=4, assert start and wr_en (K[0]=7) during STREAM:
  - No second run occurs.
  - K[0] is unchanged after the run, checked by a second run that reads the old value.
- Assert reset during the 2nd STREAM cycle: all outputs go 0 immediately, busy=0, no done, banks read 0 on the next run.
- In IDLE, write L[0]=4 in the same cycle as start (K[0]=6, len=1): pair (6,4) is emitted, sum 24.
